// File: rtl/reg_file_op_engine.sv
// Register file with a built-in operation engine.
// The engine runs SWAP, COPY or CLEAR between two captured addresses and
// reports progress through a start/busy/done/err handshake. User writes are
// dropped while the engine runs, and wr_blocked flags each dropped write.
// The read port is combinational and valid in every state.
module reg_file_op_engine #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] address_w,
    input  logic [DATA_WIDTH-1:0] data_w,
    input  logic [ADDR_WIDTH-1:0] address_r,
    output logic [DATA_WIDTH-1:0] data_r,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [ADDR_WIDTH-1:0] address_A,
    input  logic [ADDR_WIDTH-1:0] address_B,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  wr_blocked
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        OP_SWAP  = 2'b00,
        OP_COPY  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WR_A,
        WR_B,
        DONE
    } state_e;

    // Storage and engine state
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    state_e                state_q, state_d;

    // Operation parameters frozen at the accepting edge, so later changes on
    // op/address_A/address_B cannot disturb a running operation.
    op_e                   op_q;
    logic [ADDR_WIDTH-1:0] addr_a_q;
    logic [ADDR_WIDTH-1:0] addr_b_q;

    // Operand snapshots taken in LOAD; SWAP needs both before either is
    // overwritten.
    logic [DATA_WIDTH-1:0] tmp_a_q;
    logic [DATA_WIDTH-1:0] tmp_b_q;

    logic                  wr_blocked_q;

    // Engine write request, decoded from the current state
    logic                  eng_we;
    logic [ADDR_WIDTH-1:0] eng_addr;
    logic [DATA_WIDTH-1:0] eng_data;

    logic                  idle;
    logic                  accept_start;

    assign idle         = (state_q == IDLE);
    assign accept_start = idle && start;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and engine write decode.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would infer a latch.
    always_comb begin
        state_d  = state_q;
        eng_we   = 1'b0;
        eng_addr = addr_a_q;
        eng_data = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    unique case (op_e'(op))
                        OP_SWAP,
                        OP_COPY:  state_d = LOAD;
                        OP_CLEAR: state_d = WR_A;
                        default:  state_d = DONE;
                    endcase
                end
            end
            LOAD: begin
                state_d = (op_q == OP_SWAP) ? WR_A : WR_B;
            end
            WR_A: begin
                eng_we   = 1'b1;
                eng_addr = addr_a_q;
                if (op_q == OP_SWAP) begin
                    eng_data = tmp_b_q;
                    state_d  = WR_B;
                end else begin
                    eng_data = '0;
                    state_d  = DONE;
                end
            end
            WR_B: begin
                eng_we   = 1'b1;
                eng_addr = addr_b_q;
                eng_data = tmp_a_q;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the requested operation when a start is accepted in IDLE.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q     <= OP_SWAP;
            addr_a_q <= '0;
            addr_b_q <= '0;
        end else if (accept_start) begin
            op_q     <= op_e'(op);
            addr_a_q <= address_A;
            addr_b_q <= address_B;
        end
    end

    // Snapshot both operands in LOAD; a user write committed at the start
    // edge is already in mem_q and so is seen here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmp_a_q <= '0;
            tmp_b_q <= '0;
        end else if (state_q == LOAD) begin
            tmp_a_q <= mem_q[addr_a_q];
            tmp_b_q <= mem_q[addr_b_q];
        end
    end

    // Memory update: engine writes win; user writes only land in IDLE.
    // NOTE: the array is cleared on reset because the block guarantees
    // all-zero contents after reset; without that need, leaving storage
    // unreset would be preferred.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (eng_we) begin
            mem_q[eng_addr] <= eng_data;
        end else if (idle && we) begin
            mem_q[address_w] <= data_w;
        end
    end

    // Flag, for one cycle, a user write dropped because the engine was busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_blocked_q <= 1'b0;
        end else begin
            wr_blocked_q <= we && !idle;
        end
    end

    // Status outputs are plain decodes of registered state.
    assign busy       = !idle;
    assign done       = (state_q == DONE);
    assign err        = (state_q == DONE) && (op_q == OP_RSVD);
    assign wr_blocked = wr_blocked_q;

    // Combinational read port.
    assign data_r = mem_q[address_r];

endmodule
